pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage RV32 core. It generates the 6-bit per-stage stall vector and the jump-flush strobe consumed by the pc, if_id, id_exe, exe_mem and mem_wb registers. It resolves four event sources by priority:

- memory-bus wait
- multicycle divide, sequenced by an internal FSM
- load-use hazard
- taken jump/branch

It also keeps two performance counters.

---
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage RV32 core.
//
// Resolves the four stall/flush sources in priority order: memory-bus wait,
// multicycle divide, load-use hazard and taken jump. It also keeps two
// 32-bit performance counters.
//
// Ports:
//   clk_i            core clock, rising-edge active
//   rst_n_i          asynchronous active-low reset
//   id_rs1_raddr_i   rs1 address of the ID instruction; id_rs1_re_i = rs1 is read
//   id_rs2_raddr_i   rs2 address of the ID instruction; id_rs2_re_i = rs2 is read
//   ex_inst_is_load_i, ex_rd_i   EXE instruction is a load / its destination register
//   ex_mc_req_i      EXE holds a DIV/DIVU/REM/REMU (level)
//   ex_jump_i, ex_jump_addr_i    EXE resolved a taken jump / its target
//   mem_req_i, mem_ack_i         MEM access outstanding / bus completes it
//   stall_o          per-stage stop vector {wb, mem, exe, id_exe, if_id, pc}
//   flush_jump_o, jump_addr_o    flush IF/ID and ID/EXE, redirect pc
//   mc_busy_o, mc_done_o         divide sequencer active / result valid
//   stall_cnt_o, flush_cnt_o     cycles with stall_o[0] / flush_jump_o set
module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [4:0]  id_rs1_raddr_i,
    input  logic        id_rs1_re_i,
    input  logic [4:0]  id_rs2_raddr_i,
    input  logic        id_rs2_re_i,
    input  logic        ex_inst_is_load_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mc_req_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic [5:0]  stall_o,
    output logic        flush_jump_o,
    output logic [31:0] jump_addr_o,
    output logic        mc_busy_o,
    output logic        mc_done_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, flush_cnt_q;

    logic        mem_wait, div_stall, load_use;
    logic [5:0]  stall;
    logic        flush;

    // Event detection and priority resolution.
    always_comb begin
        mem_wait  = mem_req_i & ~mem_ack_i;
        div_stall = ((state_q == StIdle) & ex_mc_req_i) | (state_q == StBusy);
        load_use  = ex_inst_is_load_i & (ex_rd_i != 5'd0) &
                    ((id_rs1_re_i & (id_rs1_raddr_i == ex_rd_i)) |
                     (id_rs2_re_i & (id_rs2_raddr_i == ex_rd_i)));
        stall = 6'b000000;
        if (mem_wait) begin
            stall = 6'b011111;
        end else if (div_stall) begin
            stall = 6'b001111;
        end else if (load_use) begin
            stall = 6'b000111;
        end
        // A jump held in EXE only flushes once EXE actually advances.
        flush = ex_jump_i & ~stall[3];
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        stall_o      = 6'b000000;
        flush_jump_o = 1'b0;
        jump_addr_o  = 32'd0;
        mc_busy_o    = 1'b0;
        mc_done_o    = 1'b0;
        if (rst_n_i) begin
            stall_o      = stall;
            flush_jump_o = flush;
            jump_addr_o  = flush ? ex_jump_addr_i : 32'd0;
            mc_busy_o    = (state_q != StIdle);
            mc_done_o    = (state_q == StDone);
        end
        stall_cnt_o = stall_cnt_q;
        flush_cnt_o = flush_cnt_q;
    end

    // Divide sequencer. Requests are ignored outside IDLE, so a back-to-back
    // divide restarts one cycle after DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (ex_mc_req_i) begin
                    state_d = StBusy;
                    cnt_d   = 8'(DIV_CYCLES - 1);
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Hold the result while a memory wait freezes EXE.
                if (!stall[3]) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall[0]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with DIV_CYCLES=4: directed scenarios
// against constants plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, ex_rd;
    logic        rs1_re, rs2_re, is_load, mc_req, jump, mem_req, mem_ack;
    logic [31:0] jump_addr;
    logic [5:0]  stall;
    logic        flush, busy, done;
    logic [31:0] jaddr_o, stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctrl #(.DIV_CYCLES(DIV)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .id_rs1_raddr_i   (rs1),
        .id_rs1_re_i      (rs1_re),
        .id_rs2_raddr_i   (rs2),
        .id_rs2_re_i      (rs2_re),
        .ex_inst_is_load_i(is_load),
        .ex_rd_i          (ex_rd),
        .ex_mc_req_i      (mc_req),
        .ex_jump_i        (jump),
        .ex_jump_addr_i   (jump_addr),
        .mem_req_i        (mem_req),
        .mem_ack_i        (mem_ack),
        .stall_o          (stall),
        .flush_jump_o     (flush),
        .jump_addr_o      (jaddr_o),
        .mc_busy_o        (busy),
        .mc_done_o        (done),
        .stall_cnt_o      (stall_cnt),
        .flush_cnt_o      (flush_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // A divide is tracked as "active" plus the number of stall cycles it has
    // already consumed; it needs DIV of them before the result is ready.
    bit          m_active;
    int          m_elapsed;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    function automatic logic [5:0] m_stall();
        bit mw, ds, lu;
        mw = mem_req && !mem_ack;
        ds = m_active ? (m_elapsed < DIV) : mc_req;
        lu = is_load && ex_rd != 0 &&
             ((rs1_re && rs1 == ex_rd) || (rs2_re && rs2 == ex_rd));
        if (mw) return 6'b011111;
        if (ds) return 6'b001111;
        if (lu) return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic bit m_flush();
        logic [5:0] s;
        s = m_stall();
        return jump && !s[3];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active    <= 0;
            m_elapsed   <= 0;
            m_stall_cnt <= 0;
            m_flush_cnt <= 0;
        end else begin
            logic [5:0] s;
            s = m_stall();
            if (s[0]) m_stall_cnt <= m_stall_cnt + 1;
            if (m_flush()) m_flush_cnt <= m_flush_cnt + 1;
            if (!m_active) begin
                if (mc_req) begin
                    m_active  <= 1;
                    m_elapsed <= 1;
                end
            end else if (m_elapsed < DIV) begin
                m_elapsed <= m_elapsed + 1;
            end else if (!s[3]) begin
                m_active <= 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        rs1 = 0; rs2 = 0; rs1_re = 0; rs2_re = 0; is_load = 0; ex_rd = 0;
        mc_req = 0; jump = 0; jump_addr = 0; mem_req = 0; mem_ack = 0;
    endtask

    // Advance to the next drive point (after the falling edge).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        mem_req = 1; mc_req = 1; jump = 1; jump_addr = 32'h1234;
        #1;
        n_checks++;
        if (stall !== 6'b0 || flush !== 1'b0 || jaddr_o !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: stall=%b flush=%b addr=%h busy=%b done=%b, need all 0",
                     stall, flush, jaddr_o, busy, done);
        end
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_counters: stall_cnt=%0d flush_cnt=%0d, need 0 0", stall_cnt, flush_cnt);
        end
        repeat (2) next_cycle();
        idle_inputs();
        rst_n = 1;
        next_cycle();
        #1;
        n_checks++;
        if (stall !== 6'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: stall=%b busy=%b, need 000000 0", stall, busy);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        is_load = 1; ex_rd = 5; rs1 = 5; rs1_re = 1;
        #1;
        n_checks++;
        if (stall !== 6'b000111 || flush !== 1'b0) begin
            n_errors++;
            $display("FAIL load_use_rs1: stall=%b flush=%b, need 000111 0", stall, flush);
        end
        next_cycle();
        is_load = 0;
        #1;
        n_checks++;
        if (stall !== 6'b000000) begin
            n_errors++;
            $display("FAIL load_use_one_bubble: stall=%b, need 000000", stall);
        end
        next_cycle();
        is_load = 1; ex_rd = 0; rs1 = 0;
        #1;
        n_checks++;
        if (stall !== 6'b000000) begin
            n_errors++;
            $display("FAIL load_use_x0: stall=%b, need 000000", stall);
        end
        next_cycle();
        ex_rd = 9; rs1 = 9; rs1_re = 0; rs2 = 9; rs2_re = 1;
        #1;
        n_checks++;
        if (stall !== 6'b000111) begin
            n_errors++;
            $display("FAIL load_use_rs2: stall=%b, need 000111", stall);
        end
        next_cycle();
        rs2_re = 0;
        #1;
        n_checks++;
        if (stall !== 6'b000000) begin
            n_errors++;
            $display("FAIL load_use_no_read: stall=%b, need 000000", stall);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        next_cycle();
        mc_req = 1;
        for (int c = 1; c <= 2 * (DIV + 1); c++) begin
            bit first_div_stall, is_done, exp_busy;
            int k;
            #1;
            k = (c - 1) % (DIV + 1);  // 0..DIV within each divide
            first_div_stall = (k < DIV);
            is_done = (k == DIV);
            exp_busy = (k != 0);
            n_checks++;
            if (stall !== (first_div_stall ? 6'b001111 : 6'b000000) || done !== is_done ||
                busy !== exp_busy) begin
                n_errors++;
                $display("FAIL divide_cycle%0d: stall=%b done=%b busy=%b, need %b %b %b", c, stall,
                         done, busy, first_div_stall ? 6'b001111 : 6'b000000, is_done, exp_busy);
            end
            next_cycle();
        end
        mc_req = 0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 6'b0) begin
            n_errors++;
            $display("FAIL divide_end: busy=%b done=%b stall=%b, need 0 0 000000", busy, done, stall);
        end
    endtask

    task automatic test_mw_during_done();
        next_cycle();
        mc_req = 1;
        repeat (DIV) next_cycle();
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (stall !== 6'b011111 || done !== 1'b1) begin
                n_errors++;
                $display("FAIL mw_done_hold%0d: stall=%b done=%b, need 011111 1", i, stall, done);
            end
            next_cycle();
        end
        mem_ack = 1;
        #1;
        n_checks++;
        if (stall !== 6'b000000 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL mw_done_ack: stall=%b done=%b, need 000000 1", stall, done);
        end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL mw_done_idle: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_jump_under_mw();
        logic [31:0] base;
        next_cycle();
        base = m_flush_cnt;
        jump = 1; jump_addr = 32'h8000_0040; mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (flush !== 1'b0 || jaddr_o !== 32'd0 || stall !== 6'b011111) begin
                n_errors++;
                $display("FAIL jump_mw_hold%0d: flush=%b addr=%h stall=%b, need 0 0 011111", i,
                         flush, jaddr_o, stall);
            end
            next_cycle();
        end
        mem_ack = 1;
        #1;
        n_checks++;
        if (flush !== 1'b1 || jaddr_o !== 32'h8000_0040) begin
            n_errors++;
            $display("FAIL jump_mw_flush: flush=%b addr=%h, need 1 80000040", flush, jaddr_o);
        end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (flush_cnt !== base + 32'd1) begin
            n_errors++;
            $display("FAIL jump_mw_count: flush_cnt=%0d, need %0d", flush_cnt, base + 32'd1);
        end
    endtask

    task automatic test_async_reset();
        next_cycle();
        mc_req = 1; mem_req = 1; mem_ack = 0; jump = 1; jump_addr = 32'hdead_beef;
        repeat (2) next_cycle();
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if (stall !== 6'b0 || flush !== 1'b0 || jaddr_o !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset_outputs: stall=%b flush=%b addr=%h busy=%b done=%b, need all 0",
                     stall, flush, jaddr_o, busy, done);
        end
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL async_reset_counters: stall_cnt=%0d flush_cnt=%0d, need 0 0",
                     stall_cnt, flush_cnt);
        end
        next_cycle();
        idle_inputs();
        rst_n = 1;
        for (int i = 0; i < DIV + 2; i++) begin
            next_cycle();
            #1;
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 32'd0) begin
                n_errors++;
                $display("FAIL async_reset_after%0d: busy=%b done=%b stall_cnt=%0d, need 0 0 0", i,
                         busy, done, stall_cnt);
            end
        end
    endtask

    // ---------------- randomized traffic vs model ----------------
    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            logic [5:0]  es;
            bit          ef;
            next_cycle();
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            rs1_re    = $urandom_range(0, 1) == 1;
            rs2_re    = $urandom_range(0, 1) == 1;
            ex_rd     = 5'($urandom_range(0, 3));
            is_load   = $urandom_range(0, 2) == 0;
            mc_req    = $urandom_range(0, 7) == 0;
            jump      = $urandom_range(0, 4) == 0;
            jump_addr = $urandom;
            mem_req   = $urandom_range(0, 3) == 0;
            mem_ack   = $urandom_range(0, 1) == 1;
            #1;
            es = m_stall();
            ef = m_flush();
            n_checks++;
            if (stall !== es) begin
                n_errors++;
                $display("FAIL rand_stall c%0d: got %b need %b", c, stall, es);
            end
            n_checks++;
            if (flush !== ef || jaddr_o !== (ef ? jump_addr : 32'd0)) begin
                n_errors++;
                $display("FAIL rand_flush c%0d: got %b/%h need %b/%h", c, flush, jaddr_o, ef,
                         ef ? jump_addr : 32'd0);
            end
            n_checks++;
            if (busy !== m_active || done !== (m_active && m_elapsed >= DIV)) begin
                n_errors++;
                $display("FAIL rand_div c%0d: busy=%b done=%b need %b %b", c, busy, done, m_active,
                         m_active && m_elapsed >= DIV);
            end
            n_checks++;
            if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
                n_errors++;
                $display("FAIL rand_counters c%0d: got %0d/%0d need %0d/%0d", c, stall_cnt,
                         flush_cnt, m_stall_cnt, m_flush_cnt);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_mw_during_done();
        test_jump_under_mw();
        test_async_reset();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
